// File: rtl/aes_pkg.sv
// Shared types for the AES S-box lookup path: arbiter FSM encoding, requester IDs,
// and the request payload bundle.
package aes_pkg;

    localparam int unsigned SBOX_AW      = 8;
    localparam int unsigned SBOX_DW      = 8;
    localparam int unsigned DEF_MAX_LOCK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic               req;
        logic               lock;
        logic [SBOX_AW-1:0] addr;
    } sbox_req_t;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sbox_rr_pick.sv
// Two-way round-robin pick: on a tie the requester not granted most recently wins.
module sbox_rr_pick
    import aes_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sbox_arbiter.sv
// Arbitrates two requesters onto one single-port S-box ROM with optional bounded
// lock ownership; one lookup per cycle, result returned one cycle after the grant.
module sbox_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               lock0,
    input  logic               lock1,
    input  logic [SBOX_AW-1:0] addr0,
    input  logic [SBOX_AW-1:0] addr1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [SBOX_DW-1:0] rdata,
    output logic [SBOX_AW-1:0] sbox_addr,
    output logic               sbox_ce_n,
    output logic               sbox_re_n,
    input  logic [SBOX_DW-1:0] sbox_data_in
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, cnt_nxt;
    req_id_t          last, last_nxt;

    sbox_req_t  rq [0:1];
    logic [1:0] req_v;
    logic [1:0] lock_v;
    logic [1:0] rr_grant;
    logic [1:0] grant_c;
    logic [1:0] grant_v;
    req_id_t    own_id;
    req_id_t    gnt_id;

    assign rq[0]  = '{req: req0, lock: lock0, addr: addr0};
    assign rq[1]  = '{req: req1, lock: lock1, addr: addr1};
    assign req_v  = {rq[1].req, rq[0].req};
    assign lock_v = {rq[1].lock, rq[0].lock};

    sbox_rr_pick u_rr_pick (
        .req   (req_v),
        .last  (last),
        .grant (rr_grant)
    );

    // Grant selection and next-state/lock-count update.
    always_comb begin
        grant_c   = 2'b00;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        last_nxt  = last;
        own_id    = (state == OWN1);
        gnt_id    = 1'b0;

        case (state)
            OWN0, OWN1: begin
                if (req_v[own_id]) begin
                    // Forced release only when the budget is spent and the other side waits.
                    if ((lock_cnt < CNT_W'(MAX_LOCK)) || !req_v[~own_id]) begin
                        grant_c = id_onehot(own_id);
                    end else begin
                        grant_c = id_onehot(~own_id);
                    end
                end else begin
                    grant_c = rr_grant;
                end
            end
            default: grant_c = rr_grant;
        endcase

        if (grant_c != 2'b00) begin
            gnt_id   = grant_c[1];
            last_nxt = gnt_id;
            if (lock_v[gnt_id]) begin
                state_nxt = gnt_id ? OWN1 : OWN0;
                if (state_nxt == state) begin
                    cnt_nxt = (lock_cnt >= CNT_W'(MAX_LOCK)) ? CNT_W'(MAX_LOCK)
                                                             : lock_cnt + CNT_W'(1);
                end else begin
                    cnt_nxt = CNT_W'(1);
                end
            end
        end
    end

    // No grant can escape while reset is held, even though arbitration is combinational.
    assign grant_v   = rst ? grant_c : 2'b00;
    assign gnt0      = grant_v[0];
    assign gnt1      = grant_v[1];
    assign sbox_ce_n = ~|grant_v;
    assign sbox_re_n = ~|grant_v;
    assign sbox_addr = (grant_v != 2'b00) ? rq[gnt_id].addr : '0;
    assign rdata     = sbox_data_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last     <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= cnt_nxt;
            last     <= last_nxt;
            rvalid0  <= grant_v[0];
            rvalid1  <= grant_v[1];
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed vector bench for sbox_arbiter with a small S-box ROM model.
module tb_sbox_arbiter;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, lock0, lock1;
    logic [7:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata, sbox_addr, sbox_data_in;
    logic       sbox_ce_n, sbox_re_n;
    logic [7:0] rom_q = 8'h00;

    int errors = 0;
    int checks = 0;

    sbox_arbiter #(.MAX_LOCK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .lock0        (lock0),
        .lock1        (lock1),
        .addr0        (addr0),
        .addr1        (addr1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .sbox_addr    (sbox_addr),
        .sbox_ce_n    (sbox_ce_n),
        .sbox_re_n    (sbox_re_n),
        .sbox_data_in (sbox_data_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h63;
            8'h53:   return 8'hED;
            8'h09:   return 8'h01;
            8'hCF:   return 8'h8A;
            8'h4F:   return 8'h84;
            8'h3C:   return 8'hEB;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!sbox_ce_n && !sbox_re_n) rom_q <= sbox_f(sbox_addr);
    end
    assign sbox_data_in = rom_q;

    typedef struct {
        logic       r0, l0;
        logic [7:0] a0;
        logic       r1, l1;
        logic [7:0] a1;
        logic       g0, g1, v0, v1;
        logic [7:0] d;
        logic       idle;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r0, l0, input logic [7:0] a0,
                                input logic r1, l1, input logic [7:0] a1,
                                input logic g0, g1, v0, v1, input logic [7:0] d,
                                input logic idle);
        vec_t v;
        v.r0 = r0; v.l0 = l0; v.a0 = a0; v.r1 = r1; v.l1 = l1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.d = d; v.idle = idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, l0, input logic [7:0] a0,
                         input logic r1, l1, input logic [7:0] a1);
        req0 = r0; lock0 = l0; addr0 = a0;
        req1 = r1; lock1 = l1; addr1 = a1;
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        logic [7:0] exp_addr;
        @(posedge clk);
        #1;
        drive(v.r0, v.l0, v.a0, v.r1, v.l1, v.a1);
        @(negedge clk);
        exp_addr = v.g0 ? v.a0 : (v.g1 ? v.a1 : 8'h00);
        chk($sformatf("row%0d gnt", idx), 32'({gnt1, gnt0}), 32'({v.g1, v.g0}));
        chk($sformatf("row%0d rvalid", idx), 32'({rvalid1, rvalid0}), 32'({v.v1, v.v0}));
        chk($sformatf("row%0d rom_if", idx), 32'({sbox_ce_n, sbox_re_n, sbox_addr}),
            32'({~(v.g0 | v.g1), ~(v.g0 | v.g1), exp_addr}));
        if (v.v0 || v.v1) chk($sformatf("row%0d rdata", idx), 32'(rdata), 32'(v.d));
        if (v.idle) chk($sformatf("row%0d state", idx), 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        // Basic round-robin with two ties, then a req1-only grant.
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h53, 1,0,0,0,8'h00, 0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h53, 0,1,1,0,8'h63, 0));
        tbl.push_back(mk(1,0,8'h00, 0,0,8'h00, 1,0,0,1,8'hED, 0));
        tbl.push_back(mk(0,0,8'h00, 1,0,8'h53, 0,1,1,0,8'h63, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,1,8'hED, 0));
        // Four locked grants to req0, then req1.
        tbl.push_back(mk(1,1,8'h09, 1,0,8'h53, 1,0,0,0,8'h00, 0));
        tbl.push_back(mk(1,1,8'hCF, 1,0,8'h53, 1,0,1,0,8'h01, 0));
        tbl.push_back(mk(1,1,8'h4F, 1,0,8'h53, 1,0,1,0,8'h8A, 0));
        tbl.push_back(mk(1,1,8'h3C, 1,0,8'h53, 1,0,1,0,8'h84, 0));
        tbl.push_back(mk(0,0,8'h00, 1,0,8'h53, 0,1,1,0,8'hEB, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,1,8'hED, 0));
        // Lock held past MAX_LOCK: forced gnt1 in cycle 4, req0 regains.
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 1,0,0,0,8'h00, 0));
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 1,0,1,0,8'h63, 0));
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 1,0,1,0,8'h63, 0));
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 1,0,1,0,8'h63, 0));
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 0,1,1,0,8'h63, 0));
        tbl.push_back(mk(1,1,8'h00, 1,0,8'h53, 1,0,0,1,8'hED, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,1,0,8'h63, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,0,8'h00, 1));
        // Owner drops req after 2 locked grants: same-cycle gnt1, back to IDLE.
        tbl.push_back(mk(1,1,8'h4F, 0,0,8'h00, 1,0,0,0,8'h00, 0));
        tbl.push_back(mk(1,1,8'h4F, 1,0,8'h3C, 1,0,1,0,8'h84, 0));
        tbl.push_back(mk(0,0,8'h00, 1,0,8'h3C, 0,1,1,0,8'h84, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,1,8'hEB, 1));
        // Lone locked owner saturates, then a late req1 is force-granted.
        tbl.push_back(mk(1,1,8'hCF, 0,0,8'h00, 1,0,0,0,8'h00, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1,1,8'hCF, 0,0,8'h00, 1,0,1,0,8'h8A, 0));
        tbl.push_back(mk(1,1,8'hCF, 1,0,8'h09, 0,1,1,0,8'h8A, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,1,8'h01, 1));
        // req1 locked owner force-released into a locked req0.
        tbl.push_back(mk(0,0,8'h00, 1,1,8'h53, 0,1,0,0,8'h00, 0));
        tbl.push_back(mk(1,1,8'h09, 1,1,8'h53, 0,1,0,1,8'hED, 0));
        tbl.push_back(mk(1,1,8'h09, 1,1,8'h53, 0,1,0,1,8'hED, 0));
        tbl.push_back(mk(1,1,8'h09, 1,1,8'h53, 0,1,0,1,8'hED, 0));
        tbl.push_back(mk(1,1,8'h09, 1,1,8'h53, 1,0,0,1,8'hED, 0));
        tbl.push_back(mk(1,1,8'h09, 1,1,8'h53, 1,0,1,0,8'h01, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,1,0,8'h01, 0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,0,8'h00, 1));

        // Reset values with both requests asserted.
        rst = 1'b0;
        drive(1,1,8'h00, 1,1,8'h53);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset gnt", 32'({gnt1, gnt0}), 32'(2'b00));
        chk("reset rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
        chk("reset rom_en", 32'({sbox_ce_n, sbox_re_n}), 32'(2'b11));
        chk("reset state", 32'(dut.state), 32'(IDLE));
        chk("reset lock_cnt", 32'(dut.lock_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0,0,8'h00, 0,0,8'h00);

        foreach (tbl[i]) apply_row(tbl[i], i);

        // Reset lands right after a gnt1: its rvalid is discarded, pointer restored.
        @(posedge clk); #1; drive(1,0,8'h00, 0,0,8'h00);
        @(negedge clk);
        chk("pre_rst gnt0", 32'({gnt1, gnt0}), 32'(2'b01));
        @(posedge clk); #1; drive(0,0,8'h00, 1,0,8'h53);
        @(negedge clk);
        chk("pre_rst gnt1", 32'({gnt1, gnt0}), 32'(2'b10));
        chk("pre_rst rdata", 32'({rvalid0, rdata}), 32'({1'b1, 8'h63}));
        #1;
        rst = 1'b0;
        drive(1,0,8'h00, 1,0,8'h53);
        @(negedge clk);
        chk("in_rst rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
        chk("in_rst gnt", 32'({gnt1, gnt0, sbox_ce_n}), 32'(3'b001));
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("post_rst gnt", 32'({gnt1, gnt0}), 32'(2'b01));
        chk("post_rst rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
        @(posedge clk); #1; drive(0,0,8'h00, 0,0,8'h00);
        @(negedge clk);
        chk("post_rst rdata", 32'({rvalid1, rvalid0, rdata}), 32'({2'b01, 8'h63}));

        // Ten idle cycles: ROM stays disabled, no rvalid.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("idle%0d", c), 32'({sbox_ce_n, sbox_re_n, rvalid1, rvalid0, gnt1, gnt0}),
                32'(6'b110000));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
